// File: rtl/ram_data_sta_mirror_ctrl.sv
// Status-bit mirror controller: zero-sweeps the SDP RAM, then arbitrates set/clear/read-(clear) ops round-robin.
// Each op costs a grant cycle plus one read-modify-write cycle; requesters stall on ready until granted.
module ram_data_sta_mirror_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [ADDR_WIDTH-1:0] upd_addr,
  input  logic [DATA_WIDTH-1:0] upd_set,
  input  logic                  clr_valid,
  output logic                  clr_ready,
  input  logic [ADDR_WIDTH-1:0] clr_addr,
  input  logic [DATA_WIDTH-1:0] clr_mask,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_clr,
  output logic                  rd_data_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  init_done
);

  typedef enum logic [1:0] {INIT = 2'd0, IDLE = 2'd1, EXEC = 2'd2} state_t;
  typedef enum logic [1:0] {OP_UPD = 2'd0, OP_CLR = 2'd1, OP_RD = 2'd2} op_t;

  state_t                state_q, state_d;
  op_t                   op_q, op_d, last_q, last_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] opnd_q, opnd_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_clr_q, rd_clr_d;
  logic                  rd_data_valid_q, rd_data_valid_d;
  logic                  init_done_q, init_done_d;
  logic [2:0]            req, grant;
  logic [DATA_WIDTH-1:0] wr_data;

  assign req = {rd_valid, clr_valid, upd_valid};

  // Search order starts just after the last granted requester.
  always_comb begin
    grant = 3'b000;
    if (state_q == IDLE && !rst) begin
      case (last_q)
        OP_UPD:  grant = req[1] ? 3'b010 : req[2] ? 3'b100 : req[0] ? 3'b001 : 3'b000;
        OP_CLR:  grant = req[2] ? 3'b100 : req[0] ? 3'b001 : req[1] ? 3'b010 : 3'b000;
        default: grant = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
      endcase
    end
  end

  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    last_d          = last_q;
    addr_d          = addr_q;
    opnd_d          = opnd_q;
    rd_clr_d        = rd_clr_q;
    rd_data_d       = rd_data_q;
    rd_data_valid_d = 1'b0;
    init_done_d     = init_done_q;
    case (state_q)
      INIT: begin
        // addr_q doubles as the sweep counter and parks on the last address.
        if (addr_q == '1) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end
      IDLE: begin
        if (grant[0]) begin
          state_d = EXEC;
          op_d    = OP_UPD;
          last_d  = OP_UPD;
          addr_d  = upd_addr;
          opnd_d  = upd_set;
        end else if (grant[1]) begin
          state_d = EXEC;
          op_d    = OP_CLR;
          last_d  = OP_CLR;
          addr_d  = clr_addr;
          opnd_d  = clr_mask;
        end else if (grant[2]) begin
          state_d  = EXEC;
          op_d     = OP_RD;
          last_d   = OP_RD;
          addr_d   = rd_addr;
          opnd_d   = '0;
          rd_clr_d = rd_clr;
        end
      end
      EXEC: begin
        state_d = IDLE;
        if (op_q == OP_RD) begin
          rd_data_d       = ram_rd_data;
          rd_data_valid_d = 1'b1;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    wr_data = '0;
    if (state_q == EXEC) begin
      case (op_q)
        OP_UPD:  wr_data = ram_rd_data | opnd_q;
        OP_CLR:  wr_data = ram_rd_data & ~opnd_q;
        default: wr_data = rd_clr_q ? '0 : ram_rd_data;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= INIT;
      op_q            <= OP_UPD;
      last_q          <= OP_RD;
      addr_q          <= '0;
      opnd_q          <= '0;
      rd_clr_q        <= 1'b0;
      rd_data_q       <= '0;
      rd_data_valid_q <= 1'b0;
      init_done_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      op_q            <= op_d;
      last_q          <= last_d;
      addr_q          <= addr_d;
      opnd_q          <= opnd_d;
      rd_clr_q        <= rd_clr_d;
      rd_data_q       <= rd_data_d;
      rd_data_valid_q <= rd_data_valid_d;
      init_done_q     <= init_done_d;
    end
  end

  // Gating with rst drops an in-flight EXEC write at the reset edge.
  assign ram_wr_en     = !rst && (state_q == INIT || state_q == EXEC);
  assign ram_wr_addr   = addr_q;
  assign ram_rd_addr   = addr_q;
  assign ram_wr_data   = wr_data;
  assign upd_ready     = grant[0];
  assign clr_ready     = grant[1];
  assign rd_ready      = grant[2];
  assign rd_data_valid = rd_data_valid_q;
  assign rd_data       = rd_data_q;
  assign init_done     = init_done_q;

endmodule
